// File: rtl/shared_adder_pkg.sv
// Shared types and the round-robin search used by the adder scheduler.
package shared_adder_pkg;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam int DEF_N   = 4;
    localparam int DEF_W   = 8;
    localparam int MAX_N   = 8;
    localparam int MAX_IDW = 3;

    // Returns {found, idx}: first set bit of valid at or after ptr, wrapping at n.
    function automatic logic [MAX_IDW:0] rr_pick(
        input logic [MAX_N-1:0]   valid,
        input logic [MAX_IDW-1:0] ptr,
        input int                 n
    );
        logic               found;
        logic [MAX_IDW-1:0] idx;
        int                 j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (!found && valid[j[MAX_IDW-1:0]]) begin
                    found = 1'b1;
                    idx   = j[MAX_IDW-1:0];
                end
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/shared_adder_scheduler_if.sv
// Request/response bundle between client blocks and the shared adder scheduler.
interface shared_adder_scheduler_if #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_carry;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );
endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: one-hot grant and index of the winner.
module rr_arbiter_n
    import shared_adder_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   valid,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           found
);
    logic [MAX_N-1:0]   valid_ext;
    logic [MAX_IDW-1:0] ptr_ext;
    logic [MAX_IDW:0]   pick;

    assign valid_ext = MAX_N'(valid);
    assign ptr_ext   = MAX_IDW'(ptr);
    assign pick      = rr_pick(valid_ext, ptr_ext, N);
    assign found     = pick[MAX_IDW];
    assign idx       = pick[IDW-1:0];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = found && (idx == IDW'(gi));
        end
    endgenerate
endmodule

// File: rtl/shared_adder_scheduler.sv
// Round-robin scheduler feeding one W-bit adder into a single-entry result register.
module shared_adder_scheduler
    import shared_adder_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(N),
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_adder_scheduler_if.slave bus,
    output logic                 busy,
    output logic [CNTW-1:0]      txn_count
);
    state_t         state_reg;
    logic [IDW-1:0] rr_ptr_reg;
    logic [IDW-1:0] id_reg;
    logic [W-1:0]   sum_reg;
    logic           carry_reg;
    logic [CNTW-1:0] txn_count_reg;

    logic [W-1:0]   a_arr [N];
    logic [W-1:0]   b_arr [N];
    logic [N-1:0]   grant;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_found;
    logic           can_accept;
    logic           accept;
    logic           rsp_fire;
    logic [W:0]     sum_next;
    logic [IDW-1:0] ptr_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[gi*W +: W];
            assign b_arr[gi] = bus.req_b[gi*W +: W];
        end
    endgenerate

    rr_arbiter_n #(.N(N), .IDW(IDW)) u_arb (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_reg),
        .grant (grant),
        .idx   (gnt_idx),
        .found (gnt_found)
    );

    // rst_n gates ready so nothing is granted while reset is held.
    assign can_accept = rst_n && ((state_reg == S_EMPTY) || bus.rsp_ready);
    assign accept     = gnt_found && can_accept;
    assign rsp_fire   = (state_reg == S_FULL) && bus.rsp_ready;
    assign sum_next   = {1'b0, a_arr[gnt_idx]} + {1'b0, b_arr[gnt_idx]};
    assign ptr_next   = (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_EMPTY;
            rr_ptr_reg    <= '0;
            id_reg        <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            txn_count_reg <= '0;
        end else begin
            if (accept) begin
                state_reg            <= S_FULL;
                rr_ptr_reg           <= ptr_next;
                id_reg               <= gnt_idx;
                {carry_reg, sum_reg} <= sum_next;
            end else if (rsp_fire) begin
                state_reg <= S_EMPTY;
            end
            if (rsp_fire) begin
                txn_count_reg <= txn_count_reg + 1'b1;
            end
        end
    end

    assign bus.req_ready = grant & {N{can_accept}};
    assign bus.rsp_valid = (state_reg == S_FULL);
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_sum   = sum_reg;
    assign bus.rsp_carry = carry_reg;
    assign busy          = (state_reg == S_FULL);
    assign txn_count     = txn_count_reg;
endmodule
